icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Instruction-cache controller between the fetch stage, the 128-line x 64-bit direct-mapped instruction cache memory, and the shared memory bus. It splits the fetch address into index/tag for the cache read port and returns hit data combinationally. On a miss it issues a BUS_LOAD, tracks the single outstanding transaction tag, and writes the returned line into the cache memory through its write port, forwarding the data to fetch in the same cycle.

## Interface
- No parameters. Field widths: index 7 (addr[9:3]), tag 22 (addr[31:10]), offset 3 (addr[2:0], ignored).
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- proc2Icache_addr  in  32  fetch address
- Icache_data_out  out  64  line returned to fetch
- Icache_valid_out  out  1  Icache_data_out valid this cycle
- cachemem_data  in  64  cache memory read data
- cachemem_valid  in  1  cache memory hit (valid && tag match)
- current_index  out  7  cache read index = proc2Icache_addr[9:3]
- current_tag  out  22  cache read tag = proc2Icache_addr[31:10]
- wr_en  out  1  cache write enable
- wr_idx  out  7  cache write index
- wr_tag  out  22  cache write tag
- wr_data  out  64  cache write data
- Imem_grant  in  1  bus arbiter grants icache this cycle
- proc2mem_command  out  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2 (never driven)
- proc2mem_addr  out  32  {proc2Icache_addr[31:3], 3'b0}
- mem2proc_response  in  4  nonzero = request accepted, value is transaction tag
- mem2proc_data  in  64  returned line
- mem2proc_tag  in  4  tag of data on mem2proc_data; 0 = no data

## Operation
- States: IDLE, WAIT. Registers: state, pend_tag[3:0], miss_idx[6:0], miss_tag[21:0].
- Read path always combinational: current_index/current_tag from proc2Icache_addr.
- IDLE, cachemem_valid=1: Icache_data_out=cachemem_data, Icache_valid_out=1, command NONE.
- IDLE, cachemem_valid=0: proc2mem_command=BUS_LOAD, addr aligned. If Imem_grant && mem2proc_response!=0: latch pend_tag=response, miss_idx/miss_tag=current, go WAIT. Otherwise stay IDLE, reissue next cycle (address follows current fetch address).
- WAIT: command NONE. When mem2proc_tag==pend_tag (pend_tag!=0): wr_en=1, wr_idx=miss_idx, wr_tag=miss_tag, wr_data=mem2proc_data; clear pend_tag; go IDLE.
- Forwarding: in fill cycle, if current idx/tag equal miss_idx/miss_tag, Icache_data_out=mem2proc_data, valid=1. Otherwise valid=0 (redirected fetch; fill still written).
- In WAIT with no matching data: valid_out=0 unless cachemem_valid=1 for a changed fetch address (hit-under-miss returns data; no new request).
- Non-matching mem2proc_tag values (other requesters) ignored.
- At most one outstanding request; never issues while in WAIT.

## Timing
- Hit: 0-cycle latency, combinational.
- Miss: BUS_LOAD in the same cycle the miss is seen; accepted cycle N -> WAIT from N+1; data cycle M -> cache write at posedge ending M, forwarded during M, cachemem hit from M+1.
- Back-to-back misses: after fill cycle, next request no earlier than the following cycle.
- Reset (any state, incl. mid-WAIT): state=IDLE, pend_tag=0, miss_idx/miss_tag=0; during reset cycle wr_en=0, command=NONE, Icache_valid_out=0. A late response after reset has no match (pend_tag=0) and is dropped.
- wr_en is a single-cycle pulse; never asserted in IDLE.

## Structure
- Shared package: BUS_NONE/BUS_LOAD/BUS_STORE constants, ICACHE_IDX_W=7, ICACHE_TAG_W=22, MEM_TAG_W=4, state enum {IDLE, WAIT}.
- Single module, no sub-modules; the cache memory and bus arbiter are instantiated beside it at the fetch-stage top level.

## Test plan
- Cold miss: reset, addr=0x0000_1008, grant=1, response=3; 5 cycles later tag=3, data=0xDEAD_BEEF_0123_4567 -> wr_en one cycle, wr_idx=1, wr_tag=0x4, valid_out=1 with that data; next cycle hit from cachemem.
- Grant denied: miss with Imem_grant=0 for 3 cycles, then response=5 -> BUS_LOAD held 4 cycles, state WAIT after acceptance only.
- Redirect: miss 0x1008 accepted tag 2, fetch changes to 0x2000 (hit) -> hit data returned while WAIT; fill at tag 2 writes idx 1 with valid_out driven by hit, not fill data.
- Foreign tag: in WAIT, mem2proc_tag=7 (pend 2) -> no wr_en, stays WAIT; tag=2 -> fill.
- Reset mid-miss: accepted tag 4, reset asserted, then tag=4 data arrives -> wr_en stays 0, new miss reissues BUS_LOAD.
- Response 0 with grant: no transition, request repeated next cycle.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction-cache controller slice: memory bus
// command encodings, cache field widths and the controller state type.
package icache_ctrl_pkg;

  localparam int ICACHE_IDX_W = 7;
  localparam int ICACHE_TAG_W = 22;
  localparam int MEM_TAG_W    = 4;
  localparam int ADDR_W       = 32;
  localparam int LINE_W       = 64;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_ctrl_if.sv
// Shared memory bus as seen by the instruction cache.
//   master : the cache controller (drives command/address, receives
//            grant, response tag and returned data)
//   slave  : the bus / memory side
interface icache_ctrl_if;
  import icache_ctrl_pkg::*;

  logic                 Imem_grant;
  logic [1:0]           proc2mem_command;
  logic [ADDR_W-1:0]    proc2mem_addr;
  logic [MEM_TAG_W-1:0] mem2proc_response;
  logic [LINE_W-1:0]    mem2proc_data;
  logic [MEM_TAG_W-1:0] mem2proc_tag;

  modport master (
    input  Imem_grant, mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr
  );

  modport slave (
    output Imem_grant, mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: sits between fetch, a direct-mapped
// 128 x 64-bit cache memory and the shared memory bus.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   proc2Icache_addr    fetch address
//   Icache_data_out/valid_out   line returned to fetch (combinational)
//   cachemem_data/valid read data and hit flag from the cache memory
//   current_index/tag   cache read port address (from fetch address)
//   wr_en/idx/tag/data  cache memory write port (fill)
//   mem_bus             memory bus (master side)
module icache_ctrl
  import icache_ctrl_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       proc2Icache_addr,
  output logic [LINE_W-1:0]       Icache_data_out,
  output logic                    Icache_valid_out,
  input  logic [LINE_W-1:0]       cachemem_data,
  input  logic                    cachemem_valid,
  output logic [ICACHE_IDX_W-1:0] current_index,
  output logic [ICACHE_TAG_W-1:0] current_tag,
  output logic                    wr_en,
  output logic [ICACHE_IDX_W-1:0] wr_idx,
  output logic [ICACHE_TAG_W-1:0] wr_tag,
  output logic [LINE_W-1:0]       wr_data,
  icache_ctrl_if.master           mem_bus
);

  icache_state_e           r_state;
  logic [MEM_TAG_W-1:0]    r_pend_tag;
  logic [ICACHE_IDX_W-1:0] r_miss_idx;
  logic [ICACHE_TAG_W-1:0] r_miss_tag;

  logic w_issue;
  logic w_accept;
  logic w_fill;
  logic w_same_line;

  assign current_index = proc2Icache_addr[9:3];
  assign current_tag   = proc2Icache_addr[31:10];

  // Offset bits are cleared so the bus always sees a line-aligned address.
  assign mem_bus.proc2mem_addr = proc2Icache_addr & ~32'h7;

  assign w_same_line = (current_index == r_miss_idx) && (current_tag == r_miss_tag);

  // A request is (re)issued every IDLE miss cycle until the bus accepts it.
  assign w_issue  = !reset && (r_state == IDLE) && !cachemem_valid;
  assign w_accept = w_issue && mem_bus.Imem_grant && (mem_bus.mem2proc_response != '0);

  // pend_tag of zero never matches, which drops late responses after reset.
  assign w_fill = !reset && (r_state == WAIT) && (r_pend_tag != '0) &&
                  (mem_bus.mem2proc_tag == r_pend_tag);

  assign mem_bus.proc2mem_command = w_issue ? BUS_LOAD : BUS_NONE;

  assign wr_en   = w_fill;
  assign wr_idx  = r_miss_idx;
  assign wr_tag  = r_miss_tag;
  assign wr_data = mem_bus.mem2proc_data;

  always_comb begin
    Icache_data_out  = cachemem_data;
    Icache_valid_out = 1'b0;
    if (!reset) begin
      if (r_state == IDLE) begin
        Icache_valid_out = cachemem_valid;
      end else if (w_fill && w_same_line) begin
        // Fill forwarded straight to fetch while it is written.
        Icache_data_out  = mem_bus.mem2proc_data;
        Icache_valid_out = 1'b1;
      end else begin
        // Hit-under-miss for a fetch that moved away from the missing line.
        Icache_valid_out = cachemem_valid && !w_same_line;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pend_tag <= '0;
      r_miss_idx <= '0;
      r_miss_tag <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= WAIT;
            r_pend_tag <= mem_bus.mem2proc_response;
            r_miss_idx <= current_index;
            r_miss_tag <= current_tag;
          end
        end
        WAIT: begin
          if (w_fill) begin
            r_state    <= IDLE;
            r_pend_tag <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: owns the cache memory array and a memory-bus
// environment, and checks the controller against a line-address level model.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] proc2Icache_addr;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic [63:0] cachemem_data;
  logic        cachemem_valid;
  logic [6:0]  current_index;
  logic [21:0] current_tag;
  logic        wr_en;
  logic [6:0]  wr_idx;
  logic [21:0] wr_tag;
  logic [63:0] wr_data;

  icache_ctrl_if bus();

  icache_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .proc2Icache_addr (proc2Icache_addr),
    .Icache_data_out  (Icache_data_out),
    .Icache_valid_out (Icache_valid_out),
    .cachemem_data    (cachemem_data),
    .cachemem_valid   (cachemem_valid),
    .current_index    (current_index),
    .current_tag      (current_tag),
    .wr_en            (wr_en),
    .wr_idx           (wr_idx),
    .wr_tag           (wr_tag),
    .wr_data          (wr_data),
    .mem_bus          (bus)
  );

  always #5 clock = ~clock;

  // Stimulus for the next cycle
  logic        s_reset, s_grant;
  logic [31:0] s_addr;
  logic [3:0]  s_resp, s_mtag;
  logic [63:0] s_mdata;

  // Cache memory owned by the bench
  logic        c_val [128];
  logic [21:0] c_tag [128];
  logic [63:0] c_dat [128];

  // Model: one outstanding miss, tracked by line address
  logic        m_pend;
  logic [3:0]  m_ptag;
  logic [28:0] m_pline;

  typedef struct {
    logic [3:0]  tag;
    int          due;
    logic [63:0] data;
  } ret_t;
  ret_t env_q[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    logic [6:0] idx;
    idx = s_addr[9:3];
    reset                 = s_reset;
    proc2Icache_addr      = s_addr;
    bus.Imem_grant        = s_grant;
    bus.mem2proc_response = s_resp;
    bus.mem2proc_tag      = s_mtag;
    bus.mem2proc_data     = s_mdata;
    cachemem_valid        = c_val[idx] && (c_tag[idx] == s_addr[31:10]);
    cachemem_data         = c_dat[idx];
  endtask

  task automatic model_check();
    logic        e_valid, e_wr;
    logic [63:0] e_data;
    logic [1:0]  e_cmd;
    logic [28:0] line;
    logic        hit, fill;
    ret_t        r;
    e_valid = 1'b0; e_wr = 1'b0; e_data = '0; e_cmd = BUS_NONE;
    line = s_addr[31:3];
    hit  = cachemem_valid;
    fill = 1'b0;
    if (s_reset) begin
      m_pend = 1'b0;
    end else if (!m_pend) begin
      if (hit) begin
        e_valid = 1'b1; e_data = cachemem_data;
      end else begin
        e_cmd = BUS_LOAD;
        if (s_grant && s_resp != 4'd0) begin
          m_pend = 1'b1; m_ptag = s_resp; m_pline = line;
          r.tag = s_resp; r.due = cyc + int'($urandom_range(1, 8)); r.data = {$urandom, $urandom};
          env_q.push_back(r);
        end
      end
    end else begin
      fill = (s_mtag == m_ptag);
      if (fill && line == m_pline) begin
        e_valid = 1'b1; e_data = s_mdata;
      end else if (hit && line != m_pline) begin
        e_valid = 1'b1; e_data = cachemem_data;
      end
    end
    chk("valid_out", 64'(Icache_valid_out), 64'(e_valid));
    if (e_valid) chk("data_out", Icache_data_out, e_data);
    chk("command", 64'(bus.proc2mem_command), 64'(e_cmd));
    chk("mem_addr", 64'(bus.proc2mem_addr), 64'({s_addr[31:3], 3'b000}));
    chk("cur_index", 64'(current_index), 64'(s_addr[9:3]));
    chk("cur_tag", 64'(current_tag), 64'(s_addr[31:10]));
    e_wr = fill;
    chk("wr_en", 64'(wr_en), 64'(e_wr));
    if (fill) begin
      chk("wr_idx", 64'(wr_idx), 64'(m_pline[6:0]));
      chk("wr_tag", 64'(wr_tag), 64'(m_pline[28:7]));
      chk("wr_data", wr_data, s_mdata);
      c_val[m_pline[6:0]] = 1'b1;
      c_tag[m_pline[6:0]] = m_pline[28:7];
      c_dat[m_pline[6:0]] = s_mdata;
      m_pend = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    drive();
    @(negedge clock);
    model_check();
    cyc++;
  endtask

  function automatic logic tag_busy(input logic [3:0] t);
    foreach (env_q[i]) if (env_q[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic gen_random();
    logic [3:0] t;
    s_reset = ($urandom_range(0, 299) == 0);
    if ($urandom_range(0, 9) < 3)
      s_addr = {20'd0, 2'($urandom_range(0, 3)), 7'($urandom_range(0, 7)), 3'($urandom)};
    s_grant = ($urandom_range(0, 9) < 7);
    s_mtag  = 4'd0;
    s_mdata = {$urandom, $urandom};
    foreach (env_q[i]) begin
      if (env_q[i].due <= cyc) begin
        s_mtag = env_q[i].tag; s_mdata = env_q[i].data;
        env_q.delete(i);
        break;
      end
    end
    if (s_mtag == 4'd0 && $urandom_range(0, 9) == 0) begin
      for (int k = 0; k < 20; k++) begin
        t = 4'($urandom_range(1, 15));
        if (!tag_busy(t) && !(m_pend && t == m_ptag)) begin
          s_mtag = t;
          break;
        end
      end
    end
    s_resp = 4'd0;
    if ($urandom_range(0, 4) != 0) begin
      for (int k = 0; k < 20; k++) begin
        t = 4'($urandom_range(1, 15));
        if (!tag_busy(t)) begin
          s_resp = t;
          break;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      c_val[i] = 1'b0; c_tag[i] = '0; c_dat[i] = '0;
    end
    m_pend = 1'b0; m_ptag = '0; m_pline = '0;
    s_reset = 1'b1; s_addr = 32'h0; s_grant = 1'b0; s_resp = 4'd0;
    s_mtag = 4'd0; s_mdata = '0;
    drive();

    // Reset state
    cycle();
    chk("rst_valid", 64'(Icache_valid_out), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_cmd", 64'(bus.proc2mem_command), 64'd0);
    cycle();

    // Cold miss on 0x1008, accepted with tag 3, filled 5 cycles later
    s_reset = 1'b0; s_addr = 32'h0000_1008; s_grant = 1'b1; s_resp = 4'd3;
    cycle();
    chk("cold_cmd", 64'(bus.proc2mem_command), 64'd1);
    chk("cold_addr", 64'(bus.proc2mem_addr), 64'h1008);
    s_grant = 1'b0; s_resp = 4'd0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("cold_wait_cmd", 64'(bus.proc2mem_command), 64'd0);
    end
    s_mtag = 4'd3; s_mdata = 64'hDEAD_BEEF_0123_4567;
    cycle();
    chk("cold_wr_en", 64'(wr_en), 64'd1);
    chk("cold_wr_idx", 64'(wr_idx), 64'd1);
    chk("cold_wr_tag", 64'(wr_tag), 64'h4);
    chk("cold_fwd_valid", 64'(Icache_valid_out), 64'd1);
    chk("cold_fwd_data", Icache_data_out, 64'hDEAD_BEEF_0123_4567);
    s_mtag = 4'd0; s_mdata = '0;
    cycle();
    chk("cold_hit_valid", 64'(Icache_valid_out), 64'd1);
    chk("cold_hit_data", Icache_data_out, 64'hDEAD_BEEF_0123_4567);
    chk("cold_hit_wr_en", 64'(wr_en), 64'd0);

    // Grant withheld for 3 cycles, then accepted with tag 5
    s_addr = 32'h0000_3010; s_grant = 1'b0; s_resp = 4'd5;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("deny_cmd", 64'(bus.proc2mem_command), 64'd1);
    end
    s_grant = 1'b1;
    cycle();
    chk("deny_accept_cmd", 64'(bus.proc2mem_command), 64'd1);
    s_grant = 1'b0; s_resp = 4'd0;
    cycle();
    chk("deny_wait_cmd", 64'(bus.proc2mem_command), 64'd0);
    s_mtag = 4'd5; s_mdata = 64'h5555_0000_5555_0000;
    cycle();
    chk("deny_wr_idx", 64'(wr_idx), 64'd2);
    s_mtag = 4'd0;

    // Redirect to a hitting line while a miss is outstanding; foreign tag
    c_val[0] = 1'b1; c_tag[0] = 22'h8; c_dat[0] = 64'h1111_2222_3333_4444;
    s_addr = 32'h0000_5008; s_grant = 1'b1; s_resp = 4'd2;
    cycle();
    s_addr = 32'h0000_2000; s_grant = 1'b0; s_resp = 4'd0;
    cycle();
    chk("redir_hit_valid", 64'(Icache_valid_out), 64'd1);
    chk("redir_hit_data", Icache_data_out, 64'h1111_2222_3333_4444);
    chk("redir_cmd", 64'(bus.proc2mem_command), 64'd0);
    s_mtag = 4'd7; s_mdata = 64'h7777_7777_7777_7777;
    cycle();
    chk("foreign_wr_en", 64'(wr_en), 64'd0);
    s_mtag = 4'd2; s_mdata = 64'hABCD_0000_0000_0002;
    cycle();
    chk("redir_wr_en", 64'(wr_en), 64'd1);
    chk("redir_wr_idx", 64'(wr_idx), 64'd1);
    chk("redir_wr_tag", 64'(wr_tag), 64'h14);
    chk("redir_out_data", Icache_data_out, 64'h1111_2222_3333_4444);
    s_mtag = 4'd0;

    // Reset while a miss is outstanding; the late response must be dropped
    s_addr = 32'h0000_7018; s_grant = 1'b1; s_resp = 4'd4;
    cycle();
    s_reset = 1'b1; s_grant = 1'b0; s_resp = 4'd0;
    cycle();
    chk("midrst_cmd", 64'(bus.proc2mem_command), 64'd0);
    chk("midrst_valid", 64'(Icache_valid_out), 64'd0);
    s_reset = 1'b0; s_mtag = 4'd4; s_mdata = 64'h4444_4444_4444_4444;
    cycle();
    chk("late_wr_en", 64'(wr_en), 64'd0);
    chk("late_reissue_cmd", 64'(bus.proc2mem_command), 64'd1);
    s_mtag = 4'd0;

    // Response 0 with grant is not an acceptance
    s_grant = 1'b1; s_resp = 4'd0;
    cycle();
    cycle();
    chk("resp0_repeat_cmd", 64'(bus.proc2mem_command), 64'd1);
    s_resp = 4'd6;
    cycle();
    s_grant = 1'b0; s_resp = 4'd0; s_mtag = 4'd6; s_mdata = 64'h6666_0000_0000_6666;
    cycle();
    chk("resp0_fill_wr_idx", 64'(wr_idx), 64'd3);
    s_mtag = 4'd0;

    // Randomized traffic
    env_q.delete();
    for (int n = 0; n < 3000; n++) begin
      gen_random();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
